// File: rtl/hls_deadlock_pkg.sv
// rtl/hls_deadlock_pkg.sv - shared types and helpers for the parametrised HLS deadlock monitor
package hls_deadlock_pkg;

  typedef enum logic {
    MONITOR  = 1'b0,
    DETECTED = 1'b1
  } dl_state_e;

  // THRESH value selecting the legacy behaviour: a candidate is a hit on its first cycle
  localparam int THRESH_IMMEDIATE = 0;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hls_deadlock_chan_filter.sv
// rtl/hls_deadlock_chan_filter.sv - persistence filter for one deadlock candidate channel
module hls_deadlock_chan_filter
  import hls_deadlock_pkg::*;
#(
  parameter int THRESH = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic cand,
  output logic hit
);

  generate
    if (THRESH == THRESH_IMMEDIATE) begin : g_imm
      logic unused_ctrl;
      assign unused_ctrl = clock ^ reset ^ clear;
      assign hit = cand;
    end else begin : g_cnt
      localparam int CW = $clog2(THRESH + 1);
      logic [CW-1:0] cnt;

      // Saturates at THRESH so a long-held candidate keeps hitting every cycle
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt <= '0;
        end else if (clear || !cand) begin
          cnt <= '0;
        end else if (cnt != CW'(THRESH)) begin
          cnt <= cnt + 1'b1;
        end
      end

      assign hit = cand && (cnt == CW'(THRESH));
    end
  endgenerate

endmodule

// File: rtl/hls_deadlock_param_monitor.sv
// rtl/hls_deadlock_param_monitor.sv - filtered per-instance HLS deadlock detector with capture and cycle count
module hls_deadlock_param_monitor
  import hls_deadlock_pkg::*;
#(
  parameter int                    NUM_AXIS   = 7,
  parameter int                    NUM_INST   = 1,
  parameter logic [NUM_AXIS-1:0]   WATCH_MASK = 7'b0111110,
  parameter int                    THRESH     = 16,
  parameter bit                    STICKY     = 1'b1,
  parameter int                    CYC_W      = 16
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        clear,
  input  logic [NUM_AXIS-1:0]                         axis_block_sigs,
  input  logic [NUM_AXIS-1:0]                         inst_idle_sigs,
  input  logic [NUM_INST-1:0]                         inst_block_sigs,
  output logic                                        block,
  output logic                                        block_pulse,
  output logic [idx_width(NUM_AXIS+NUM_INST)-1:0]     block_idx,
  output logic [NUM_AXIS+NUM_INST-1:0]                block_snapshot,
  output logic [CYC_W-1:0]                            block_cycles
);

  localparam int NCH = NUM_AXIS + NUM_INST;
  localparam int IW  = idx_width(NCH);

  logic [NCH-1:0] cand;
  logic [NCH-1:0] hit;
  logic           any_hit;
  logic [IW-1:0]  sel_idx;

  assign cand    = {inst_block_sigs, axis_block_sigs & ~inst_idle_sigs & WATCH_MASK};
  assign any_hit = |hit;

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_chan
      hls_deadlock_chan_filter #(.THRESH(THRESH)) u_filter (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .cand  (cand[c]),
        .hit   (hit[c])
      );
    end
  endgenerate

  always_comb begin
    sel_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hit[i]) sel_idx = IW'(i);
    end
  end

  dl_state_e        state_q, state_d;
  logic             pulse_q, pulse_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NCH-1:0]   snap_q, snap_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= MONITOR;
      pulse_q <= 1'b0;
      idx_q   <= '0;
      snap_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      cyc_q   <= cyc_d;
    end
  end

  // Capture fields hold their value after a non-sticky exit until the next detection
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    idx_d   = idx_q;
    snap_d  = snap_q;
    cyc_d   = cyc_q;
    if (clear) begin
      state_d = MONITOR;
      idx_d   = '0;
      snap_d  = '0;
      cyc_d   = '0;
    end else begin
      case (state_q)
        MONITOR: begin
          if (any_hit) begin
            state_d = DETECTED;
            pulse_d = 1'b1;
            idx_d   = sel_idx;
            snap_d  = {inst_block_sigs, axis_block_sigs};
            cyc_d   = CYC_W'(1);
          end
        end
        DETECTED: begin
          if (!STICKY && !any_hit) begin
            state_d = MONITOR;
          end else if (cyc_q != '1) begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        default: state_d = MONITOR;
      endcase
    end
  end

  assign block          = (state_q == DETECTED);
  assign block_pulse    = pulse_q;
  assign block_idx      = idx_q;
  assign block_snapshot = snap_q;
  assign block_cycles   = cyc_q;

endmodule

// File: tb/tb_hls_deadlock_param_monitor.sv
// tb/tb_hls_deadlock_param_monitor.sv - self-checking bench for hls_deadlock_param_monitor
module tb_hls_deadlock_param_monitor;

  localparam logic [6:0] MASK = 7'b0111110;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic [6:0] axis_block_sigs;
  logic [6:0] inst_idle_sigs;
  logic [0:0] inst_block_sigs;

  always #5 clock = ~clock;

  logic a_blk, a_pls, b_blk, b_pls, c_blk, c_pls, d_blk, d_pls;
  logic [2:0] a_idx, b_idx, c_idx, d_idx;
  logic [7:0] a_snap, b_snap, c_snap, d_snap;
  logic [15:0] a_cyc, b_cyc, c_cyc;
  logic [3:0] d_cyc;

  hls_deadlock_param_monitor #(.THRESH(4), .STICKY(1'b1), .CYC_W(16)) u_a (
    .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .block(a_blk),
    .block_pulse(a_pls), .block_idx(a_idx), .block_snapshot(a_snap), .block_cycles(a_cyc));
  hls_deadlock_param_monitor #(.THRESH(0), .STICKY(1'b1), .CYC_W(16)) u_b (
    .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .block(b_blk),
    .block_pulse(b_pls), .block_idx(b_idx), .block_snapshot(b_snap), .block_cycles(b_cyc));
  hls_deadlock_param_monitor #(.THRESH(4), .STICKY(1'b0), .CYC_W(16)) u_c (
    .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .block(c_blk),
    .block_pulse(c_pls), .block_idx(c_idx), .block_snapshot(c_snap), .block_cycles(c_cyc));
  hls_deadlock_param_monitor #(.THRESH(2), .STICKY(1'b1), .CYC_W(4)) u_d (
    .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .block(d_blk),
    .block_pulse(d_pls), .block_idx(d_idx), .block_snapshot(d_snap), .block_cycles(d_cyc));

  // Model: per channel, the number of consecutive sampled edges the candidate has been high
  int thr  [4] = '{4, 0, 4, 2};
  bit stk  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  int cmax [4] = '{65535, 65535, 65535, 15};
  int run  [4][8];
  int m_blk[4], m_pls[4], m_idx[4], m_snap[4], m_cyc[4];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 8; c++) run[k][c] = 0;
      m_blk[k] = 0; m_pls[k] = 0; m_idx[k] = 0; m_snap[k] = 0; m_cyc[k] = 0;
    end
  endtask

  task automatic model_step();
    bit cand [8];
    for (int c = 0; c < 7; c++) cand[c] = MASK[c] & axis_block_sigs[c] & ~inst_idle_sigs[c];
    cand[7] = inst_block_sigs[0];
    for (int k = 0; k < 4; k++) begin
      int sel;
      sel = -1;
      for (int c = 7; c >= 0; c--) if (cand[c] && run[k][c] >= thr[k]) sel = c;
      m_pls[k] = 0;
      if (clear) begin
        for (int c = 0; c < 8; c++) run[k][c] = 0;
        m_blk[k] = 0; m_idx[k] = 0; m_snap[k] = 0; m_cyc[k] = 0;
      end else begin
        for (int c = 0; c < 8; c++) run[k][c] = cand[c] ? run[k][c] + 1 : 0;
        if (m_blk[k] == 0) begin
          if (sel >= 0) begin
            m_blk[k]  = 1;
            m_pls[k]  = 1;
            m_idx[k]  = sel;
            m_snap[k] = int'(inst_block_sigs) * 128 + int'(axis_block_sigs);
            m_cyc[k]  = 1;
          end
        end else if (!stk[k] && sel < 0) begin
          m_blk[k] = 0;
        end else if (m_cyc[k] < cmax[k]) begin
          m_cyc[k]++;
        end
      end
    end
  endtask

  task automatic get_dut(input int k, output int b, output int p, output int i,
                         output int s, output int c);
    case (k)
      0: begin b = a_blk; p = a_pls; i = a_idx; s = a_snap; c = a_cyc; end
      1: begin b = b_blk; p = b_pls; i = b_idx; s = b_snap; c = b_cyc; end
      2: begin b = c_blk; p = c_pls; i = c_idx; s = c_snap; c = c_cyc; end
      default: begin b = d_blk; p = d_pls; i = d_idx; s = d_snap; c = d_cyc; end
    endcase
  endtask

  task automatic compare_all();
    int b, p, i, s, c;
    for (int k = 0; k < 4; k++) begin
      get_dut(k, b, p, i, s, c);
      check($sformatf("u%0d.block", k), b, m_blk[k]);
      check($sformatf("u%0d.block_pulse", k), p, m_pls[k]);
      check($sformatf("u%0d.block_idx", k), i, m_idx[k]);
      check($sformatf("u%0d.block_snapshot", k), s, m_snap[k]);
      check($sformatf("u%0d.block_cycles", k), c, m_cyc[k]);
    end
  endtask

  task automatic tick(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clock);
      @(negedge clock);
      if (!reset) model_reset();
      else model_step();
      compare_all();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; clear = 1'b0;
    axis_block_sigs = '0; inst_idle_sigs = '0; inst_block_sigs = '0;
    model_reset();
    tick(2);
    check("reset.block", a_blk, 0);
    check("reset.cycles", a_cyc, 0);
    reset = 1'b1;
    tick(2);

    // Held candidate on axis 2
    axis_block_sigs = 7'b0000100;
    tick(4);
    check("s1.a_block_before", a_blk, 0);
    check("s1.b_block_immediate", b_blk, 1);
    check("s1.d_cycles", d_cyc, 2);
    tick(1);
    check("s1.a_block", a_blk, 1);
    check("s1.a_pulse", a_pls, 1);
    check("s1.a_idx", a_idx, 2);
    check("s1.a_snap", a_snap, 8'h04);
    check("s1.a_cycles", a_cyc, 1);
    tick(1);
    check("s1.a_pulse_one", a_pls, 0);
    check("s1.a_cycles_inc", a_cyc, 2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0; axis_block_sigs = '0;
    check("clr.a_block", a_blk, 0);
    check("clr.a_cycles", a_cyc, 0);

    // Interrupted run never reaches THRESH=4
    axis_block_sigs = 7'b0000100; tick(3);
    axis_block_sigs = 7'b0000000; tick(1);
    axis_block_sigs = 7'b0000100; tick(3);
    check("s2.a_block", a_blk, 0);
    check("s2.c_block", c_blk, 0);
    axis_block_sigs = '0; clear = 1'b1;
    tick(1);
    clear = 1'b0;

    // Idle-qualified channel 1 and masked channel 0
    axis_block_sigs = 7'b0000011; inst_idle_sigs = 7'b0000010;
    tick(50);
    check("s3.a_block", a_blk, 0);
    check("s3.b_block", b_blk, 0);
    check("s3.d_block", d_blk, 0);
    axis_block_sigs = '0; inst_idle_sigs = '0;

    // Simultaneous hits on 3 and 5
    axis_block_sigs = 7'b0101000;
    tick(1);
    check("s4.b_block", b_blk, 1);
    check("s4.b_idx", b_idx, 3);
    check("s4.b_snap", b_snap, 8'h28);
    tick(4);
    check("s4.a_block", a_blk, 1);
    check("s4.a_idx", a_idx, 3);
    axis_block_sigs = '0; clear = 1'b1;
    tick(1);
    clear = 1'b0;

    // Sticky versus non-sticky release on axis 4
    axis_block_sigs = 7'b0010000;
    tick(5);
    check("s5.c_block", c_blk, 1);
    check("s5.c_idx", c_idx, 4);
    axis_block_sigs = '0;
    tick(1);
    check("s5.c_released", c_blk, 0);
    check("s5.c_idx_held", c_idx, 4);
    check("s5.c_cycles_held", c_cyc, 1);
    check("s5.a_sticky", a_blk, 1);
    check("s5.a_cycles", a_cyc, 2);
    tick(3);
    check("s5.a_still", a_blk, 1);
    check("s5.a_cycles_later", a_cyc, 5);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("s5.a_cleared", a_blk, 0);
    check("s5.a_cycles_cleared", a_cyc, 0);
    check("s5.c_idx_cleared", c_idx, 0);

    // Saturation on the 4-bit counter, then asynchronous reset mid-detection
    axis_block_sigs = 7'b0010000;
    tick(20);
    check("s6.d_saturated", d_cyc, 15);
    check("s6.a_cycles", a_cyc, 16);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("s6.a_block_async", a_blk, 0);
    check("s6.d_cycles_async", d_cyc, 0);
    axis_block_sigs = '0;
    tick(1);
    reset = 1'b1;
    tick(3);
    check("s6.no_pulse", a_pls, 0);
    check("s6.no_block", a_blk, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hls_deadlock_param_monitor.md
Name: hls_deadlock_param_monitor

Overview:
- Parametrised successor of the per-instance HLS deadlock monitor.
- Watches a configurable set of AXIS block signals, qualified by instance idle status, plus the instance block signals.
- Filters each candidate for a programmable persistence window, then flags a deadlock.
- Captures which channel fired and a snapshot of the inputs, optionally holds the flag until cleared, and counts blocked cycles. It sits under the top-level deadlock detector, one instance per monitored HLS sub-instance.

Parameters:
- NUM_AXIS, 7, number of AXIS block/idle signal pairs.
- NUM_INST, 1, number of instance block signals.
- WATCH_MASK, 7'b0111110, bit i=1 means axis channel i is monitored; width NUM_AXIS.
- THRESH, 16, consecutive asserted cycles before a channel counts as blocked; 0 means immediate (legacy behaviour).
- STICKY, 1, 1 = block held until clear; 0 = block follows the filtered condition.
- CYC_W, 16, width of the blocked-cycle counter.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of detection state and counters.
- axis_block_sigs  in  NUM_AXIS  per-channel AXIS blocked indication.
- inst_idle_sigs  in  NUM_AXIS  per-channel idle of the owning instance.
- inst_block_sigs  in  NUM_INST  instance-level block indications.
- block  out  1  deadlock flag.
- block_pulse  out  1  one-cycle strobe on entry to DETECTED.
- block_idx  out  $clog2(NUM_AXIS+NUM_INST)  lowest-index channel that triggered; inst channels numbered NUM_AXIS+j.
- block_snapshot  out  NUM_AXIS+NUM_INST  {inst_block_sigs, axis_block_sigs} captured at detection.
- block_cycles  out  CYC_W  cycles spent in DETECTED, saturating at all-ones.

Behaviour:
- Reset (reset==0, async): all outputs 0, all filter counters 0, FSM = MONITOR.
- Channel candidate:
  - axis i: cand_i = WATCH_MASK[i] & axis_block_sigs[i] & ~inst_idle_sigs[i].
  - inst j: cand = inst_block_sigs[j].
- Filter per channel:
  - cnt <= cand ? min(cnt+1, THRESH) : 0.
  - hit = (cnt==THRESH) & cand.
  - THRESH==0: hit = cand, no counter.
- Deasserting cand for one cycle zeroes cnt.
- any_hit = OR of all hits. sel_idx = lowest-index hit.
- FSM MONITOR → DETECTED on any_hit:
  - next edge: block=1, block_pulse=1 for exactly that cycle, block_idx=sel_idx, block_snapshot=current inputs, block_cycles=1.
- FSM DETECTED:
  - block_cycles increments each cycle, saturating.
  - block_idx and block_snapshot stay frozen.
  - STICKY=0 and !any_hit → MONITOR: block=0 next edge; idx, snapshot and cycles keep their last value until the next detection.
  - STICKY=1: stays until clear.
- clear=1: next edge FSM=MONITOR, all counters 0, all outputs 0.
  - clear has priority over a simultaneous hit.
  - Detection restarts from an empty filter.
- Latency (cand high continuously from sampling edge 0):
  - THRESH>0: block rises at edge THRESH+1.
  - THRESH==0: block rises at edge 1.
- Simultaneous hits on several channels: lowest index is reported; all are visible in the snapshot.
- Masked channels (WATCH_MASK=0) never count, whatever the input.
- Reset asserted mid-detection: immediate return to reset values, no pulse on release.

Decomposition:
- Shared package (hls_deadlock_pkg):
  - FSM state encoding MONITOR/DETECTED.
  - Index-width helper function.
  - Common constant for the legacy immediate mode (THRESH=0).
- One sub-module: hls_deadlock_chan_filter.
  - Parameter THRESH; ports clock, reset, clear, cand, hit.
  - Instantiated NUM_AXIS+NUM_INST times via generate.

Test Plan:
- THRESH=4, axis[2]=1, idle[2]=0 held → block=1, block_pulse high one cycle at edge 5, block_idx=2, snapshot bit2=1, block_cycles=1 then increments.
- THRESH=4, axis[2] high 3 cycles, low 1 cycle, high 3 cycles → block stays 0 throughout.
- axis[1]=1 with inst_idle_sigs[1]=1 for 50 cycles, and axis[0]=1 (masked) → block stays 0.
- THRESH=0, axis[3] and axis[5] asserted together at edge 0 → block=1 at edge 1, block_idx=3, snapshot=…0101000.
- STICKY=0: detect on axis[4], then drop it → block=0 one edge later, block_idx stays 4. STICKY=1 with the same stimulus → block stays 1 until clear, then 0 and block_cycles=0.
- Detection active and reset pulsed low asynchronously mid-cycle → outputs 0 immediately. Release with no inputs → no block_pulse; block_cycles saturation check with CYC_W=4 → holds at 15.
